// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one multi-cycle divider among NUM_REQ requesters.
// Optional macro DIV_ZERO_BYPASS_EN answers divide-by-zero locally without starting the divider.
module div_arbiter #(
  parameter int MSB     = 31,
  parameter int NUM_REQ = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [NUM_REQ-1:0][MSB:0]     ReqDivident,
  input  logic [NUM_REQ-1:0][MSB:0]     ReqDivisor,
  output logic [NUM_REQ-1:0]            ReqReady,
  output logic [NUM_REQ-1:0]            RspValid,
  output logic [MSB:0]                  RspQuotient,
  output logic [MSB:0]                  RspReminder,
  output logic                          DivStart,
  output logic [MSB:0]                  DivDivident,
  output logic [MSB:0]                  DivDivisor,
  input  logic                          DivDone,
  input  logic [MSB:0]                  DivQuotient,
  input  logic [MSB:0]                  DivReminder
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MSB + 4);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, owner, grant_idx;
  logic [PTR_W:0]     idx;
  logic               found, accept, zero_div;
  logic [NUM_REQ-1:0] grant;
  logic [MSB:0]       acc_divident, acc_divisor;
  logic [CNT_W-1:0]   busy_cnt;

  // Round-robin search starting at ptr and wrapping past NUM_REQ-1.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(off);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && ReqValid[idx[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
    grant = '0;
    if (found) grant[grant_idx] = 1'b1;
  end

  assign acc_divident = ReqDivident[grant_idx];
  assign acc_divisor  = ReqDivisor[grant_idx];
  assign accept       = found && (state == IDLE) && !Reset;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_div = (acc_divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      busy_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner <= grant_idx;
        ptr   <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
      if (state == START)                busy_cnt <= '0;
      else if (state == BUSY && !DivDone) busy_cnt <= busy_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_div ? RESP : START;
      START:   state_nxt = BUSY;
      BUSY:    if (DivDone) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low during Reset so nothing is granted or pulsed in that cycle.
  always_comb begin
    ReqReady = '0;
    RspValid = '0;
    DivStart = 1'b0;
    if (!Reset) begin
      if (state == IDLE)  ReqReady = grant;
      if (state == RESP)  RspValid[owner] = 1'b1;
      if (state == START) DivStart = 1'b1;
    end
  end

  // Operand capture p0 / result capture p1
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DivDivident <= '0;
      DivDivisor  <= '0;
      RspQuotient <= '0;
      RspReminder <= '0;
    end else begin
      if (accept) begin
        DivDivident <= acc_divident;
        DivDivisor  <= acc_divisor;
      end
      if (accept && zero_div) begin
        RspQuotient <= '1;
        RspReminder <= acc_divident;
      end else if (state == BUSY && DivDone) begin
        RspQuotient <= DivQuotient;
        RspReminder <= DivReminder;
      end
    end
  end

  // The attached divider must finish within MSB+2 busy cycles.
  assert property (@(posedge Clk) disable iff (Reset)
    (state == BUSY) |-> (busy_cnt <= CNT_W'(MSB + 2)));

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: scoreboard bench for div_arbiter with a behavioural shift-subtract divider model.
module tb_div_arbiter;
  localparam int MSB     = 31;
  localparam int NUM_REQ = 2;
  localparam int LAT     = MSB + 5;

  logic                      Clk = 1'b0;
  logic                      Reset;
  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ-1:0][MSB:0] ReqDivident, ReqDivisor;
  logic [NUM_REQ-1:0]        ReqReady, RspValid;
  logic [MSB:0]              RspQuotient, RspReminder;
  logic                      DivStart;
  logic [MSB:0]              DivDivident, DivDivisor;
  logic                      DivDone;
  logic [MSB:0]              DivQuotient, DivReminder;

  div_arbiter #(.MSB(MSB), .NUM_REQ(NUM_REQ)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqDivident(ReqDivident),
    .ReqDivisor(ReqDivisor), .ReqReady(ReqReady), .RspValid(RspValid),
    .RspQuotient(RspQuotient), .RspReminder(RspReminder), .DivStart(DivStart),
    .DivDivident(DivDivident), .DivDivisor(DivDivisor), .DivDone(DivDone),
    .DivQuotient(DivQuotient), .DivReminder(DivReminder)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int           owner;
    logic [MSB:0] q;
    logic [MSB:0] r;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           grant_log[$];
  logic [MSB:0] qa[NUM_REQ][$];
  logic [MSB:0] qb[NUM_REQ][$];
  int           n_checks = 0, n_errors = 0;
  int           cyc = 0, last_acc = 0, n_rsp = 0, n_start = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Divider model: Done low for MSB+2 cycles after Start, garbage outputs while busy.
  int           div_cnt;
  logic [MSB:0] div_q, div_r;
  always @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= 0; DivDone <= 1'b1; DivQuotient <= '0; DivReminder <= '0;
    end else if (DivStart) begin
      div_cnt     <= MSB + 2;
      DivDone     <= 1'b0;
      DivQuotient <= 32'hDEADBEEF;
      DivReminder <= 32'hDEADBEEF;
      div_q       <= (DivDivisor == 0) ? '1 : DivDivident / DivDivisor;
      div_r       <= (DivDivisor == 0) ? DivDivident : DivDivident % DivDivisor;
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) begin
        DivDone <= 1'b1; DivQuotient <= div_q; DivReminder <= div_r;
      end
    end
  end

  // Scoreboard: push on accept, pop and compare on response.
  exp_t         e_mon;
  logic [MSB:0] mon_a, mon_b;
  always @(negedge Clk) begin
    if (Reset) begin
      sb.delete();
    end else begin
      if (ReqReady != '0) check("ready_onehot", 64'($onehot(ReqReady)), 64'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ReqValid[i] && ReqReady[i]) begin
          mon_a       = ReqDivident[i];
          mon_b       = ReqDivisor[i];
          e_mon.owner = i;
          e_mon.q     = (mon_b == 0) ? '1 : mon_a / mon_b;
          e_mon.r     = (mon_b == 0) ? mon_a : mon_a % mon_b;
          e_mon.acc   = cyc;
`ifdef DIV_ZERO_BYPASS_EN
          e_mon.lat   = (mon_b == 0) ? 1 : LAT;
`else
          e_mon.lat   = LAT;
`endif
          sb.push_back(e_mon);
          grant_log.push_back(i);
          last_acc = cyc;
        end
      end
      if (DivStart) begin
        n_start++;
        check("start_lat", 64'(cyc - last_acc), 64'd1);
      end
      if (RspValid != '0) begin
        n_rsp++;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(RspValid), 64'd0);
        end else begin
          e_mon = sb.pop_front();
          check("rsp_valid", 64'(RspValid), 64'(1) << e_mon.owner);
          check("rsp_quotient", 64'(RspQuotient), 64'(e_mon.q));
          check("rsp_remainder", 64'(RspReminder), 64'(e_mon.r));
          check("rsp_latency", 64'(cyc - e_mon.acc), 64'(e_mon.lat));
        end
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  // Drives queued ops; after each accept the operands are scrambled until the next op is loaded.
  task automatic run_ops(int budget);
    bit acc[NUM_REQ];
    bit done = 1'b0;
    int n = 0;
    while (!done && n < budget) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!ReqValid[i] && qa[i].size() > 0) begin
          ReqDivident[i] = qa[i][0];
          ReqDivisor[i]  = qb[i][0];
          ReqValid[i]    = 1'b1;
        end
      @(negedge Clk);
      for (int i = 0; i < NUM_REQ; i++) acc[i] = ReqValid[i] & ReqReady[i];
      @(posedge Clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (acc[i]) begin
          void'(qa[i].pop_front());
          void'(qb[i].pop_front());
          ReqValid[i]    = 1'b0;
          ReqDivident[i] = ~ReqDivident[i];
          ReqDivisor[i]  = 32'd1;
        end
      done = (ReqValid == '0) && (sb.size() == 0);
      for (int i = 0; i < NUM_REQ; i++) if (qa[i].size() != 0) done = 1'b0;
      n++;
    end
    check("run_ops_complete", 64'(done), 64'd1);
    for (int i = 0; i < NUM_REQ; i++) begin qa[i].delete(); qb[i].delete(); end
    ReqValid = '0;
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_ready"}, 64'(ReqReady), 64'd0);
    check({tag, "_rspvalid"}, 64'(RspValid), 64'd0);
    check({tag, "_start"}, 64'(DivStart), 64'd0);
    check({tag, "_rspq"}, 64'(RspQuotient), 64'd0);
    check({tag, "_rspr"}, 64'(RspReminder), 64'd0);
    check({tag, "_divdividend"}, 64'(DivDivident), 64'd0);
    check({tag, "_divdivisor"}, 64'(DivDivisor), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_before, s_before;
    Reset = 1'b1; ReqValid = '0; ReqDivident = '0; ReqDivisor = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check_zero_outputs("reset");

    // Single op
    @(posedge Clk); #1;
    qa[0].push_back(32'd100); qb[0].push_back(32'd7);
    run_ops(200);
    check("single_hold_q", 64'(RspQuotient), 64'd14);
    check("single_hold_r", 64'(RspReminder), 64'd2);

    // Reset while the divider is busy
    n_before = n_rsp;
    ReqDivident[0] = 32'd100; ReqDivisor[0] = 32'd7; ReqValid[0] = 1'b1;
    @(negedge Clk);
    check("midreset_grant", 64'(ReqReady), 64'd1);
    @(posedge Clk); #1 ReqValid[0] = 1'b0;
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check_zero_outputs("midreset");
    repeat (45) @(negedge Clk);
    check("midreset_no_rsp", 64'(n_rsp), 64'(n_before));
    @(posedge Clk); #1;
    ReqDivident[1] = 32'd9; ReqDivisor[1] = 32'd3; ReqValid[1] = 1'b1;
    @(negedge Clk);
    check("midreset_idle_grant", 64'(ReqReady), 64'd2);
    @(posedge Clk); #1 ReqValid[1] = 1'b0;
    wait_drain(100);

    // Contention from reset
    do_reset();
    grant_log.delete();
    qa[0].push_back(32'hFFFFFFFF); qb[0].push_back(32'd16);
    qa[1].push_back(32'd5);        qb[1].push_back(32'd9);
    run_ops(300);
    check("contend_count", 64'(grant_log.size()), 64'd2);
    check("contend_first", 64'(grant_log[0]), 64'd0);
    check("contend_second", 64'(grant_log[1]), 64'd1);

    // Fairness over six back-to-back ops
    do_reset();
    grant_log.delete();
    for (int k = 0; k < 3; k++) begin
      qa[0].push_back(32'(1000 + 17 * k)); qb[0].push_back(32'(3 + k));
      qa[1].push_back(32'(77 * (k + 1)));  qb[1].push_back(32'(11 - k));
    end
    run_ops(600);
    check("fair_count", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      check($sformatf("fair_grant%0d", k), 64'(grant_log[k]), 64'(k % 2));

    // Operand isolation: inputs are scrambled right after accept
    qa[0].push_back(32'd1000); qb[0].push_back(32'd10);
    run_ops(200);
    check("isolate_div_operand", 64'(DivDivident), 64'd1000);
    check("isolate_q", 64'(RspQuotient), 64'd100);

    // Random operands
    for (int k = 0; k < 4; k++) begin
      qa[k % 2].push_back(32'($urandom));
      qb[k % 2].push_back(32'($urandom_range(1, 5000)));
    end
    run_ops(800);

    // Divide by zero
    s_before = n_start;
    qa[1].push_back(32'd42); qb[1].push_back(32'd0);
    run_ops(200);
`ifdef DIV_ZERO_BYPASS_EN
    check("divzero_no_start", 64'(n_start), 64'(s_before));
`else
    check("divzero_start", 64'(n_start), 64'(s_before + 1));
`endif
    check("divzero_q", 64'(RspQuotient), 64'hFFFFFFFF);
    check("divzero_r", 64'(RspReminder), 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
